// File: rtl/serial_deser.sv
// serial_deser: LSB-first serial-to-parallel receiver with two's-complement magnitude.
//
// Ports:
//   clk    in   1      single rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      frame start strobe (sampled in IDLE, or in DONE together with ack)
//   A      in   1      serial two's-complement data, LSB first, one bit per clock
//   ack    in   1      consumer acknowledge, releases the held result
//   P      out  WIDTH  received word
//   MAG    out  WIDTH  unsigned magnitude of P
//   SIGN   out  1      MSB of P
//   valid  out  1      result on P/MAG/SIGN is complete and stable
//   busy   out  1      frame capture in progress
module serial_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             A,
    input  logic             ack,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] MAG,
    output logic             SIGN,
    output logic             valid,
    output logic             busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_mag;
    logic             r_sign;
    logic             w_cap0;
    logic             w_last;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_mag;

    // A new frame begins from IDLE on start, or straight out of DONE when the
    // consumer acknowledges and restarts on the same edge.
    assign w_cap0 = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && ack));
    assign w_last = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);

    // The completed word merges the final serial bit as MSB, so P is loaded on
    // the same edge that captures it.
    assign w_word = {A, r_sr[WIDTH-2:0]};
    // Most-negative value wraps to 2^(WIDTH-1), which is its true magnitude.
    assign w_mag  = A ? (~w_word + ONE) : w_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
            S_DONE:  w_next = ack ? (start ? S_SHIFT : S_IDLE) : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state == S_SHIFT);
        valid = (r_state == S_DONE);
    end

    // Shift register is kept apart from P so the previous result stays visible
    // while the next frame is being captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sr   <= '0;
            r_p    <= '0;
            r_mag  <= '0;
            r_sign <= 1'b0;
        end else if (w_cap0) begin
            r_sr[0] <= A;
            r_cnt   <= CNT_ONE;
        end else if (r_state == S_SHIFT) begin
            r_sr[r_cnt] <= A;
            r_cnt       <= w_last ? '0 : r_cnt + CNT_ONE;
            if (w_last) begin
                r_p    <= w_word;
                r_sign <= A;
                r_mag  <= w_mag;
            end
        end
    end

    assign P    = r_p;
    assign MAG  = r_mag;
    assign SIGN = r_sign;
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed self-checking bench for serial_deser at WIDTH=8.
module tb_serial_deser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       A = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] P;
    logic [7:0] MAG;
    logic       SIGN;
    logic       valid;
    logic       busy;
    int         n_checks = 0;
    int         n_errors = 0;

    serial_deser #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .ack(ack),
        .P(P), .MAG(MAG), .SIGN(SIGN), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] p, input logic [7:0] m,
                             input logic s, input logic v, input logic b);
        chk({tag, ".P"}, 32'(P), 32'(p));
        chk({tag, ".MAG"}, 32'(MAG), 32'(m));
        chk({tag, ".SIGN"}, 32'(SIGN), 32'(s));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    // Sends one 8-bit frame LSB first; start is re-pulsed at bit restart_at
    // (use -1 for none), and b2b raises ack with the first start edge.
    task automatic send(input logic [7:0] w, input int restart_at, input logic b2b);
        for (int i = 0; i < 8; i++) begin
            A     = w[i];
            start = (i == 0) || (i == restart_at);
            ack   = b2b && (i == 0);
            tick();
            start = 1'b0;
            ack   = 1'b0;
        end
    endtask

    initial begin
        tick();
        check_out("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack.valid", 32'(valid), 32'd0);
        chk("idle_ack.busy", 32'(busy), 32'd0);

        A = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_edge.busy", 32'(busy), 32'd1);
        chk("first_edge.valid", 32'(valid), 32'd0);
        for (int i = 1; i < 8; i++) begin
            A = 1'(8'h05 >> i);
            tick();
        end
        check_out("f05", 8'h05, 8'h05, 1'b0, 1'b1, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_out("ack05", 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);

        send(8'hFB, -1, 1'b0);
        check_out("fFB", 8'hFB, 8'h05, 1'b1, 1'b1, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;

        send(8'h80, -1, 1'b0);
        check_out("f80", 8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            A = i[0];
            tick();
        end
        start = 1'b0;
        check_out("hold80", 8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        check_out("rel80", 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);

        send(8'h3C, 3, 1'b0);
        check_out("restart3C", 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;

        for (int i = 0; i < 5; i++) begin
            A     = 1'(8'hAA >> i);
            start = (i == 0);
            tick();
        end
        start = 1'b0;
        chk("mid.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_out("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        send(8'h05, -1, 1'b0);
        check_out("post_rst05", 8'h05, 8'h05, 1'b0, 1'b1, 1'b0);

        A = 1'b1; start = 1'b1; ack = 1'b1;
        tick();
        start = 1'b0; ack = 1'b0;
        check_out("b2b_first", 8'h05, 8'h05, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 7; i++) begin
            A = 1'(8'hFB >> i);
            tick();
        end
        check_out("b2b_bit6", 8'h05, 8'h05, 1'b0, 1'b0, 1'b1);
        A = 1'b1;
        tick();
        check_out("b2bFB", 8'hFB, 8'h05, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the serial frame length in bits and the parallel word width (legal range 2..32).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  frame start strobe; SHALL be sampled only in IDLE, or in DONE together with ack.
REQ-005 A  input  1  serial two's-complement data, LSB first, one bit per clock.
REQ-006 ack  input  1  consumer acknowledge; SHALL release the valid result.
REQ-007 P  output  WIDTH  received word, two's complement.
REQ-008 MAG  output  WIDTH  unsigned magnitude of P.
REQ-009 SIGN  output  1  MSB of P.
REQ-010 valid  output  1  result on P/MAG/SIGN is complete and stable.
REQ-011 busy  output  1  frame capture in progress.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL capture A as bit 0 on that same edge, clear the bit counter to 1, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL capture A into bit position counter, and SHALL increment the counter.
REQ-015 The edge that captures bit WIDTH-1 SHALL load P, SIGN=bit WIDTH-1, and MAG (see REQ-016), and SHALL enter DONE; valid SHALL be 1 in the following cycle (WIDTH edges from the start edge).
REQ-016 MAG SHALL equal P when SIGN=0, and (~P+1) mod 2^WIDTH when SIGN=1; the most-negative value SHALL yield MAG=2^(WIDTH-1) with no error flag.
REQ-017 P, MAG and SIGN SHALL change only on the edge entering DONE, and SHALL hold their value at all other times.
REQ-018 busy SHALL be 1 exactly in SHIFT; valid SHALL be 1 exactly in DONE.
REQ-019 In DONE, ack=1 with start=0 SHALL return the FSM to IDLE; ack=0 SHALL hold DONE indefinitely, regardless of start.
REQ-020 In DONE, ack=1 with start=1 on the same edge SHALL capture A as bit 0 of a new frame and enter SHIFT (back-to-back frames, no idle cycle).
REQ-021 start SHALL be ignored during SHIFT; the frame in progress SHALL continue unaffected.
REQ-022 ack SHALL be ignored in IDLE and SHIFT.
REQ-023 A SHALL be a don't-care in IDLE and in DONE, except on a start edge.
REQ-024 The internal shift register SHALL be separate from P, so that P holds the previous result during a new frame until that frame completes.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, counter 0, P=0, MAG=0, SIGN=0, valid=0, busy=0.
REQ-026 Asserting rst mid-frame SHALL discard the partial frame.
REQ-027 After rst deasserts, the first start SHALL begin a fresh frame at bit 0.

Verification (WIDTH=8)
REQ-028 The bench SHALL cover: start with serial bits 1,0,1,0,0,0,0,0 -> after 8 edges valid=1, P=0x05, SIGN=0, MAG=0x05, busy=0.
REQ-029 The bench SHALL cover: serial 0xFB LSB-first (1,1,0,1,1,1,1,1) -> P=0xFB, SIGN=1, MAG=0x05.
REQ-030 The bench SHALL cover: serial 0x80 -> P=0x80, SIGN=1, MAG=0x80; with ack held 0 for 5 cycles -> valid stays 1 and outputs are unchanged.
REQ-031 The bench SHALL cover: start pulsed again at bit 3 of a frame -> ignored, and the frame completes with the correct P after 8 edges.
REQ-032 The bench SHALL cover: rst pulsed after bit 4 of a frame -> all outputs 0 immediately; a new 0x05 frame after reset -> P=0x05.
REQ-033 The bench SHALL cover: in DONE holding 0x05, ack=1 and start=1 with serial 0xFB -> busy=1 on the next cycle, P stays 0x05 until 8 edges later, then P=0xFB and valid=1.
